hwpe_stream_tcdm_reader: RTL and testbench
==========================================

HWPE_STREAM_TCDM_READER -- requirements
Module: hwpe_stream_tcdm_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, response-buffer depth in 32-bit words (power of 2, >=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the word-count and transfer counters.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports, clock and reset first:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- clear_i  in  1  synchronous soft clear, same effect as rst_i.
- req_start_i  in  1  start request.
- base_addr_i  in  32  first byte address.
- stride_i  in  32  byte increment per word.
- length_i  in  CNT_WIDTH  number of words to read.
- ready_start_o  out  1  block idle and accepting start.
- done_o  out  1  one-cycle end-of-transfer pulse.
- busy_o  out  1  transfer in progress.
- tcdm_req_o  out  1  TCDM request.
- tcdm_gnt_i  in  1  TCDM grant.
- tcdm_add_o  out  32  TCDM byte address.
- tcdm_wen_o  out  1  write enable, active-low; constant 1 (read).
- tcdm_be_o  out  4  byte enable; 4'hF.
- tcdm_data_o  out  32  write data; constant 0.
- tcdm_r_data_i  in  32  read data.
- tcdm_r_valid_i  in  1  read data valid.
- stream_valid_o  out  1  output stream valid.
- stream_ready_i  in  1  output stream ready.
- stream_data_o  out  32  output stream data.
- stream_strb_o  out  4  output stream strobe; 4'hF while valid, else 0.

Function
REQ-005 SHALL implement FSM IDLE, WORKING, DRAIN; ready_start_o=1 only in IDLE; busy_o=1 in WORKING or DRAIN.
REQ-006 SHALL, in IDLE, on req_start_i with length_i!=0: latch base, stride and length; set addr=base_addr_i, issued=0; go to WORKING next cycle.
REQ-007 SHALL, in IDLE, on req_start_i with length_i==0: stay IDLE and pulse done_o in the next cycle.
REQ-008 SHALL ignore req_start_i outside IDLE; latched parameters stay stable until the next start.
REQ-009 SHALL define credits = FIFO_DEPTH - fifo_count - outstanding, all registered values.
REQ-010 SHALL assert tcdm_req_o in WORKING only when issued<length and credits>0; tcdm_add_o=addr; tcdm_add_o=0 whenever tcdm_req_o=0.
REQ-011 SHALL, on tcdm_req_o & tcdm_gnt_i: addr += stride modulo 2^32 (wrap silently), issued += 1, outstanding += 1.
REQ-012 SHALL hold addr and tcdm_req_o unchanged while the request is not granted.
REQ-013 SHALL transition WORKING->DRAIN in the cycle after the grant that makes issued==length.
REQ-014 SHALL, on tcdm_r_valid_i with outstanding>0: push tcdm_r_data_i into the FIFO and decrement outstanding.
REQ-015 SHALL ignore tcdm_r_valid_i when outstanding==0, including after reset or clear.
REQ-016 SHALL, when a grant and an r_valid occur in the same cycle, leave outstanding unchanged.
REQ-017 SHALL make response order equal request order; the FIFO is in-order.
REQ-018 SHALL drive stream_valid_o = FIFO not empty, with stream_data_o = FIFO head (registered).
REQ-019 SHALL hold data stable while valid and not ready; a pop occurs on valid & ready.
REQ-020 SHALL leave fifo_count unchanged on a simultaneous push and pop, including when the FIFO is full.
REQ-021 SHALL, by construction of the credit rule, never overflow the FIFO; pushing into a full FIFO is an assertion error.
REQ-022 SHALL give a latency of 2 cycles from grant to stream_valid_o with TCDM r_valid 1 cycle after grant: grant at t, r_valid at t+1, stream_valid_o at t+2.
REQ-023 SHALL sustain 1 word/cycle when gnt=1 and stream_ready_i=1 continuously.
REQ-024 SHALL, in DRAIN, go to IDLE when outstanding==0, FIFO empty, and no push in the current cycle.
REQ-025 SHALL pulse done_o high for exactly one cycle, in the first IDLE cycle after DRAIN.
REQ-026 SHALL use issued and length counters that are CNT_WIDTH bits; the maximum transfer is 2^CNT_WIDTH-1 words.

Reset
REQ-027 SHALL, on rst_i or clear_i at a clock edge: state=IDLE, addr=0, issued=0, outstanding=0, FIFO emptied, done_o=0.
REQ-028 SHALL drive outputs during reset: tcdm_req_o=0, stream_valid_o=0, ready_start_o=1, busy_o=0.
REQ-029 SHALL apply reset or clear mid-transfer with the same priority as above; stale in-flight responses are dropped (REQ-015) and no done_o pulse is produced.

Verification
REQ-030 SHALL cover: base=0x100, stride=4, length=8, gnt=1, ready=1 -> addresses 0x100..0x11C, 8 stream words in order, done_o 1 cycle after the last pop.
REQ-031 SHALL cover: same transfer with stream_ready_i=0 -> exactly 4 grants then tcdm_req_o=0; after ready rises, the remaining 4 words complete in order.
REQ-032 SHALL cover: gnt toggling 1-0-1 -> tcdm_add_o held during the non-granted cycle; no address skipped or repeated.
REQ-033 SHALL cover: base=0xFFFFFFF8, stride=4, length=4 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
REQ-034 SHALL cover: length=0 start -> no tcdm_req_o, done_o pulse next cycle, ready_start_o stays 1.
REQ-035 SHALL cover: clear_i asserted with 2 words outstanding -> IDLE next cycle, late r_valids ignored, stream_valid_o=0, no done_o pulse.

Source files
------------

// File: rtl/hwpe_stream_tcdm_reader.sv
// hwpe_stream_tcdm_reader
//
// Purpose: reads `length` 32-bit words from TCDM at base, base+stride, ...
// (byte addresses, wrapping modulo 2^32) and streams them out in request
// order. Requests are throttled by a credit count so that every issued read
// is guaranteed a slot in the response FIFO; responses are never back-pressured.
//
// Ports:
//   clk_i, rst_i, clear_i        clock, synchronous active-high reset / soft clear
//   req_start_i, base_addr_i,    start handshake with transfer parameters
//   stride_i, length_i
//   ready_start_o, done_o,       idle/accepting, one-cycle end pulse, busy
//   busy_o
//   tcdm_*                       TCDM read master (req/gnt, r_valid/r_data)
//   stream_*                     32-bit output stream (valid/ready, data, strobe)
module hwpe_stream_tcdm_reader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 req_start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [31:0]          stride_i,
    input  logic [CNT_WIDTH-1:0] length_i,
    output logic                 ready_start_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [31:0]          tcdm_add_o,
    output logic                 tcdm_wen_o,
    output logic [3:0]           tcdm_be_o,
    output logic [31:0]          tcdm_data_o,
    input  logic [31:0]          tcdm_r_data_i,
    input  logic                 tcdm_r_valid_i,
    output logic                 stream_valid_o,
    input  logic                 stream_ready_i,
    output logic [31:0]          stream_data_o,
    output logic [3:0]           stream_strb_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WORKING = 2'd1,
        DRAIN   = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [31:0]                  addr_q, addr_d;
    logic [31:0]                  stride_q, stride_d;
    logic [CNT_WIDTH-1:0]         length_q, length_d;
    logic [CNT_WIDTH-1:0]         issued_q, issued_d;
    logic [OCC_W-1:0]             outstanding_q, outstanding_d;
    logic [OCC_W-1:0]             fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [FIFO_DEPTH-1:0][31:0]  mem_q, mem_d;
    logic                         done_q, done_d;

    logic                         soft_rst;
    logic [OCC_W-1:0]             credits;
    logic                         grant;
    logic                         push;
    logic                         pop;
    logic                         fifo_full;

    assign soft_rst  = rst_i | clear_i;

    // Every word either sits in the FIFO or is still in flight; a request is
    // only issued when a FIFO slot is reserved for its response.
    assign credits   = OCC_W'(FIFO_DEPTH) - fifo_count_q - outstanding_q;
    assign fifo_full = (fifo_count_q == OCC_W'(FIFO_DEPTH));

    // Outputs are forced to their idle values while reset/clear is high so the
    // block looks idle even before the first reset edge has been taken.
    assign tcdm_req_o     = ~soft_rst && (state_q == WORKING) &&
                            (issued_q < length_q) && (credits != '0);
    assign tcdm_add_o     = tcdm_req_o ? addr_q : 32'h0;
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_be_o      = 4'hF;
    assign tcdm_data_o    = 32'h0;

    assign stream_valid_o = ~soft_rst && (fifo_count_q != '0);
    assign stream_data_o  = mem_q[rd_ptr_q];
    assign stream_strb_o  = stream_valid_o ? 4'hF : 4'h0;

    assign ready_start_o  = soft_rst || (state_q == IDLE);
    assign busy_o         = ~soft_rst && (state_q != IDLE);
    assign done_o         = ~soft_rst && done_q;

    assign grant = tcdm_req_o & tcdm_gnt_i;
    // Responses with nothing in flight are stale (from before a clear) and dropped.
    assign push  = tcdm_r_valid_i && (outstanding_q != '0);
    assign pop   = stream_valid_o & stream_ready_i;

    // Transfer control
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        length_d = length_q;
        issued_d = issued_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_start_i) begin
                    if (length_i != '0) begin
                        state_d  = WORKING;
                        addr_d   = base_addr_i;
                        stride_d = stride_i;
                        length_d = length_i;
                        issued_d = '0;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            WORKING: begin
                if (grant) begin
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + 1'b1;
                    if (issued_d == length_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((outstanding_q == '0) && (fifo_count_q == '0) && !push) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In-flight counter and response FIFO
    always_comb begin
        outstanding_d = outstanding_q;
        fifo_count_d  = fifo_count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        mem_d         = mem_q;

        case ({grant, push})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = tcdm_r_data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            stride_q      <= '0;
            length_q      <= '0;
            issued_q      <= '0;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mem_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            stride_q      <= stride_d;
            length_q      <= length_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mem_q         <= mem_d;
            done_q        <= done_d;
        end
    end

    // The credit rule bounds fifo_count + outstanding by FIFO_DEPTH, so a
    // push can never land in a full buffer.
    no_fifo_overflow: assert property (
        @(posedge clk_i) disable iff (rst_i || clear_i)
        !(push && fifo_full && !pop)
    );

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Bench for hwpe_stream_tcdm_reader: a TCDM slave returning in-order reads,
// a counting reference model (grants / responses / pops) checked every cycle,
// a table of directed transfers, hand-written length-0 and clear sequences,
// and randomized transfers.
module tb_hwpe_stream_tcdm_reader;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_i, clear_i, req_start_i;
    logic [31:0]   base_addr_i, stride_i;
    logic [CW-1:0] length_i;
    logic          ready_start_o, done_o, busy_o;
    logic          tcdm_req_o, tcdm_gnt_i;
    logic [31:0]   tcdm_add_o;
    logic          tcdm_wen_o;
    logic [3:0]    tcdm_be_o;
    logic [31:0]   tcdm_data_o, tcdm_r_data_i;
    logic          tcdm_r_valid_i;
    logic          stream_valid_o, stream_ready_i;
    logic [31:0]   stream_data_o;
    logic [3:0]    stream_strb_o;

    hwpe_stream_tcdm_reader #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .req_start_i(req_start_i), .base_addr_i(base_addr_i),
        .stride_i(stride_i), .length_i(length_i),
        .ready_start_o(ready_start_o), .done_o(done_o), .busy_o(busy_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .stream_valid_o(stream_valid_o), .stream_ready_i(stream_ready_i),
        .stream_data_o(stream_data_o), .stream_strb_o(stream_strb_o)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        int          len;
        int          gnt_pat;   // 0: always, 1: 1-0-1 toggle, 2: random
        int          rdy_pat;   // 0: always, 1: low for 10 cycles, 2: random
        logic [31:0] exp_last;  // last granted address
        int          exp_cyc;   // cycles from start to drain end, -1: don't care
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          live, exp_done, resp_en;
    int unsigned g, p, rv, len_m;
    logic [31:0] base_m, stride_m, last_gnt_addr;
    logic [31:0] resp_q[$];
    int          done_cnt;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, act, exp);
        end
    endtask

    task automatic chkb(input string n, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", n, $time, act, exp);
        end
    endtask

    // One clock cycle: inputs already set by the caller at posedge+1.
    task automatic tick();
        bit          deliver, rst_now, exp_req, exp_val, hs_g, hs_p, start_acc, drain_done;
        logic [31:0] a;
        int unsigned g0;
        deliver        = resp_en && (resp_q.size() > 0);
        tcdm_r_valid_i = deliver;
        tcdm_r_data_i  = deliver ? memfn(resp_q[0]) : 32'hDEAD_BEEF;
        #2;
        rst_now = rst_i || clear_i;
        // outstanding + buffered words == grants - pops
        exp_req = !rst_now && live && (g < len_m) && ((g - p) < DEPTH);
        chkb("tcdm_req", tcdm_req_o, exp_req);
        chk("tcdm_add", tcdm_add_o, exp_req ? base_m + 32'(g) * stride_m : 32'h0);
        exp_val = !rst_now && live && (rv > p);
        chkb("stream_valid", stream_valid_o, exp_val);
        if (exp_val) chk("stream_data", stream_data_o, memfn(base_m + 32'(p) * stride_m));
        chk("stream_strb", 32'(stream_strb_o), exp_val ? 32'hF : 32'h0);
        chkb("done", done_o, exp_done);
        chkb("ready_start", ready_start_o, rst_now || !live);
        chkb("busy", busy_o, !rst_now && live);
        chkb("tcdm_wen", tcdm_wen_o, 1'b1);
        chk("tcdm_be", 32'(tcdm_be_o), 32'hF);
        chk("tcdm_wdata", tcdm_data_o, 32'h0);
        if (done_o) done_cnt++;

        hs_g       = tcdm_req_o && tcdm_gnt_i;
        a          = tcdm_add_o;
        hs_p       = stream_valid_o && stream_ready_i;
        start_acc  = !rst_now && !live && req_start_i;
        drain_done = live && (g == len_m) && (rv == len_m) && (p == len_m);
        g0         = g;

        @(posedge clk);
        #1;
        if (deliver) resp_q.delete(0);
        exp_done = 1'b0;
        if (rst_now) begin
            live = 1'b0; g = 0; p = 0; rv = 0;
        end else begin
            if (hs_g) begin
                g++;
                resp_q.push_back(a);
                last_gnt_addr = a;
            end
            if (hs_p) p++;
            if (deliver && live && (rv < g0)) rv++;
            if (drain_done) begin
                live     = 1'b0;
                exp_done = 1'b1;
            end
            if (start_acc) begin
                if (length_i != '0) begin
                    live = 1'b1; g = 0; p = 0; rv = 0;
                    base_m = base_addr_i; stride_m = stride_i; len_m = 32'(length_i);
                end else begin
                    exp_done = 1'b1;
                end
            end
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int cyc;
        done_cnt       = 0;
        base_addr_i    = v.base;
        stride_i       = v.stride;
        length_i       = CW'(v.len);
        req_start_i    = 1'b1;
        tcdm_gnt_i     = 1'b1;
        stream_ready_i = 1'b1;
        resp_en        = 1'b1;
        tick();
        req_start_i = 1'b0;
        cyc = 0;
        while (live && cyc < 400) begin
            case (v.gnt_pat)
                0:       tcdm_gnt_i = 1'b1;
                1:       tcdm_gnt_i = (cyc % 2 == 0);
                default: tcdm_gnt_i = ($urandom_range(0, 2) != 0);
            endcase
            case (v.rdy_pat)
                0:       stream_ready_i = 1'b1;
                1:       stream_ready_i = (cyc >= 10);
                default: stream_ready_i = ($urandom_range(0, 2) != 0);
            endcase
            resp_en = (v.gnt_pat == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            cyc++;
            if (v.rdy_pat == 1 && cyc == 10) begin
                chk("grants_while_stalled", 32'(g), 32'd4);
                chkb("req_while_stalled", tcdm_req_o, 1'b0);
            end
        end
        chkb("xfer_timeout", live, 1'b0);
        if (live) begin
            rst_i = 1'b1;
            tick();
            rst_i = 1'b0;
            resp_q.delete();
            return;
        end
        tcdm_gnt_i     = 1'b0;
        stream_ready_i = 1'b1;
        resp_en        = 1'b1;
        tick();  // first IDLE cycle: done pulse
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("last_addr", last_gnt_addr, v.exp_last);
        chk("words_out", 32'(p), 32'(v.len));
        if (v.exp_cyc >= 0) chk("xfer_cycles", 32'(cyc), 32'(v.exp_cyc));
    endtask

    initial begin
        vec_t vecs[6];
        vecs[0] = '{32'h0000_0100, 32'h4,         8, 0, 0, 32'h0000_011C, 11};
        vecs[1] = '{32'h0000_0100, 32'h4,         8, 0, 1, 32'h0000_011C, -1};
        vecs[2] = '{32'h0000_0200, 32'h8,         5, 1, 0, 32'h0000_0220, 12};
        vecs[3] = '{32'hFFFF_FFF8, 32'h4,         4, 0, 0, 32'h0000_0004, 7};
        vecs[4] = '{32'h0000_0040, 32'hFFFF_FFFC, 3, 0, 0, 32'h0000_0038, 6};
        vecs[5] = '{32'h0000_1000, 32'h0,         6, 2, 2, 32'h0000_1000, -1};

        rst_i = 1'b1; clear_i = 1'b0; req_start_i = 1'b0;
        base_addr_i = '0; stride_i = '0; length_i = '0;
        tcdm_gnt_i = 1'b0; stream_ready_i = 1'b0;
        tcdm_r_valid_i = 1'b0; tcdm_r_data_i = '0;
        resp_en = 1'b1; live = 1'b0; exp_done = 1'b0;
        g = 0; p = 0; rv = 0; len_m = 0; base_m = '0; stride_m = '0;
        last_gnt_addr = '0; done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        tick();               // outputs while reset is held
        rst_i = 1'b0;
        resp_q.push_back(32'h0000_BAD0);
        tick();               // spurious r_valid with nothing in flight
        tick();
        chkb("spurious_rvalid_dropped", stream_valid_o, 1'b0);

        foreach (vecs[i]) run_xfer(vecs[i]);

        // zero-length start
        done_cnt = 0;
        base_addr_i = 32'h500; stride_i = 32'h4; length_i = '0;
        req_start_i = 1'b1; tcdm_gnt_i = 1'b1;
        tick();
        req_start_i = 1'b0;
        tick();
        tick();
        chk("len0_done_pulses", 32'(done_cnt), 32'd1);

        // clear with two reads in flight
        done_cnt = 0;
        base_addr_i = 32'h300; stride_i = 32'h4; length_i = CW'(8);
        req_start_i = 1'b1; tcdm_gnt_i = 1'b1; stream_ready_i = 1'b0; resp_en = 1'b0;
        tick();
        req_start_i = 1'b0;
        tick();
        tick();
        chk("clear_setup_grants", 32'(g), 32'd2);
        clear_i = 1'b1; tcdm_gnt_i = 1'b0;
        tick();
        clear_i = 1'b0; resp_en = 1'b1; stream_ready_i = 1'b1;
        chkb("clear_idle", ready_start_o, 1'b1);
        repeat (4) tick();
        chkb("clear_stream_empty", stream_valid_o, 1'b0);
        chk("clear_no_done", 32'(done_cnt), 32'd0);

        // randomized transfers
        for (int i = 0; i < 15; i++) begin
            vec_t v;
            v.base     = $urandom;
            v.stride   = (i % 3 == 0) ? $urandom : (32'($urandom_range(0, 16)) << 2);
            v.len      = int'($urandom_range(1, 10));
            v.gnt_pat  = 2;
            v.rdy_pat  = 2;
            v.exp_last = v.base + 32'(v.len - 1) * v.stride;
            v.exp_cyc  = -1;
            run_xfer(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
